// File: rtl/ifu_mem_arb.sv
// Arbitrates demand and prefetch line-fill requests onto one memory port, with a single request outstanding.
// Optional demand-into-prefetch merging is enabled by defining IFU_ARB_MERGE_EN.
module ifu_mem_arb #(
  parameter int TAG_WIDTH = 28
) (
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 dmd_reqValidIn,
  input  logic [TAG_WIDTH-1:0] dmd_reqTagIn,
  output logic                 dmd_reqReadyOut,
  input  logic                 pref_reqValidIn,
  input  logic [TAG_WIDTH-1:0] pref_reqTagIn,
  output logic                 pref_reqReadyOut,
  output logic                 mem_reqValidOut,
  output logic [TAG_WIDTH-1:0] mem_reqTagOut,
  input  logic                 mem_reqReadyIn,
  input  logic                 mem_rspValidIn,
  input  logic [TAG_WIDTH-1:0] mem_rspTagIn,
  output logic                 dmd_rspValidOut,
  output logic                 pref_rspValidOut,
  output logic [TAG_WIDTH-1:0] rspTagOut,
  output logic [1:0]           current_stateOut,
  output logic                 errStrayOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [TAG_WIDTH-1:0] tag_reg, tag_next;
  logic                 owner_pref_reg, owner_pref_next;
  logic                 merge_reg, merge_next;
  logic                 dmd_rsp_reg, dmd_rsp_next;
  logic                 pref_rsp_reg, pref_rsp_next;
  logic [TAG_WIDTH-1:0] rsp_tag_reg, rsp_tag_next;
  logic                 err_reg, err_next;

  logic                 busy;
  logic                 rsp_match;
  logic                 merge_accept;

  assign busy      = (state_reg == REQ) || (state_reg == WAIT);
  assign rsp_match = (state_reg == WAIT) && mem_rspValidIn && (mem_rspTagIn == tag_reg);

`ifdef IFU_ARB_MERGE_EN
  // A demand for the line already being prefetched rides along on that request.
  assign merge_accept = Rst && busy && owner_pref_reg && !merge_reg &&
                        dmd_reqValidIn && (dmd_reqTagIn == tag_reg);
`else
  assign merge_accept = 1'b0;
`endif

  assign dmd_reqReadyOut  = Rst && ((state_reg == IDLE) || merge_accept);
  assign pref_reqReadyOut = Rst && (state_reg == IDLE) && !dmd_reqValidIn;

  assign mem_reqValidOut  = (state_reg == REQ);
  assign mem_reqTagOut    = mem_reqValidOut ? tag_reg : '0;

  assign dmd_rspValidOut  = dmd_rsp_reg;
  assign pref_rspValidOut = pref_rsp_reg;
  assign rspTagOut        = rsp_tag_reg;
  assign current_stateOut = state_reg;
  assign errStrayOut      = err_reg;

  always_comb begin
    state_next      = state_reg;
    tag_next        = tag_reg;
    owner_pref_next = owner_pref_reg;
    merge_next      = merge_reg || merge_accept;
    dmd_rsp_next    = 1'b0;
    pref_rsp_next   = 1'b0;
    rsp_tag_next    = '0;
    err_next        = err_reg || (mem_rspValidIn && !rsp_match);

    case (state_reg)
      IDLE: begin
        merge_next = 1'b0;
        if (dmd_reqValidIn) begin
          state_next      = REQ;
          tag_next        = dmd_reqTagIn;
          owner_pref_next = 1'b0;
        end else if (pref_reqValidIn) begin
          state_next      = REQ;
          tag_next        = pref_reqTagIn;
          owner_pref_next = 1'b1;
        end
      end
      REQ: begin
        if (mem_reqReadyIn) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (rsp_match) begin
          state_next    = IDLE;
          // A merge arriving alongside the response still gets its pulse.
          dmd_rsp_next  = !owner_pref_reg || merge_reg || merge_accept;
          pref_rsp_next = owner_pref_reg;
          rsp_tag_next  = tag_reg;
          merge_next    = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        merge_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_reg      <= IDLE;
      tag_reg        <= '0;
      owner_pref_reg <= 1'b0;
      merge_reg      <= 1'b0;
      dmd_rsp_reg    <= 1'b0;
      pref_rsp_reg   <= 1'b0;
      rsp_tag_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tag_reg        <= tag_next;
      owner_pref_reg <= owner_pref_next;
      merge_reg      <= merge_next;
      dmd_rsp_reg    <= dmd_rsp_next;
      pref_rsp_reg   <= pref_rsp_next;
      rsp_tag_reg    <= rsp_tag_next;
      err_reg        <= err_next;
    end
  end

endmodule

// File: tb/tb_ifu_mem_arb.sv
// Self-checking bench for ifu_mem_arb: transaction-level model compared every cycle plus directed literal checks.
// Honours IFU_ARB_MERGE_EN so the same bench covers both builds.
module tb_ifu_mem_arb;

  localparam int TW = 28;
`ifdef IFU_ARB_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Rst;
  logic          dmd_valid, pref_valid, mem_ready, rsp_valid;
  logic [TW-1:0] dmd_tag, pref_tag, rsp_tag_in;
  logic          dmd_reqReadyOut, pref_reqReadyOut, mem_reqValidOut;
  logic [TW-1:0] mem_reqTagOut, rspTagOut;
  logic          dmd_rspValidOut, pref_rspValidOut, errStrayOut;
  logic [1:0]    current_stateOut;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0, dp_cnt = 0, pp_cnt = 0, both_cnt = 0;

  ifu_mem_arb #(.TAG_WIDTH(TW)) dut (
    .Clock           (Clock),
    .Rst             (Rst),
    .dmd_reqValidIn  (dmd_valid),
    .dmd_reqTagIn    (dmd_tag),
    .dmd_reqReadyOut (dmd_reqReadyOut),
    .pref_reqValidIn (pref_valid),
    .pref_reqTagIn   (pref_tag),
    .pref_reqReadyOut(pref_reqReadyOut),
    .mem_reqValidOut (mem_reqValidOut),
    .mem_reqTagOut   (mem_reqTagOut),
    .mem_reqReadyIn  (mem_ready),
    .mem_rspValidIn  (rsp_valid),
    .mem_rspTagIn    (rsp_tag_in),
    .dmd_rspValidOut (dmd_rspValidOut),
    .pref_rspValidOut(pref_rspValidOut),
    .rspTagOut       (rspTagOut),
    .current_stateOut(current_stateOut),
    .errStrayOut     (errStrayOut)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding fill with flags for issued / merged.
  bit            model_ok = 1'b0;
  logic          m_busy, m_sent, m_pref, m_merged, m_err;
  logic          m_dmd_pulse, m_pref_pulse;
  logic [TW-1:0] m_tag, m_rsp_tag;
  logic          m_match, m_merge_ok;

  assign m_match    = m_busy && m_sent && rsp_valid && (rsp_tag_in == m_tag);
  assign m_merge_ok = MERGE && Rst && m_busy && m_pref && !m_merged && dmd_valid && (dmd_tag == m_tag);

  always @(posedge Clock) begin
    if (!Rst) begin
      model_ok     <= 1'b1;
      m_busy       <= 1'b0;
      m_sent       <= 1'b0;
      m_pref       <= 1'b0;
      m_merged     <= 1'b0;
      m_err        <= 1'b0;
      m_dmd_pulse  <= 1'b0;
      m_pref_pulse <= 1'b0;
      m_tag        <= '0;
      m_rsp_tag    <= '0;
    end else begin
      m_dmd_pulse  <= m_match && (!m_pref || m_merged || m_merge_ok);
      m_pref_pulse <= m_match && m_pref;
      m_rsp_tag    <= m_match ? m_tag : '0;
      if (rsp_valid && !m_match) m_err <= 1'b1;
      if (m_match) begin
        m_busy   <= 1'b0;
        m_sent   <= 1'b0;
        m_merged <= 1'b0;
      end else if (!m_busy) begin
        if (dmd_valid) begin
          m_busy <= 1'b1; m_tag <= dmd_tag; m_pref <= 1'b0; m_merged <= 1'b0;
        end else if (pref_valid) begin
          m_busy <= 1'b1; m_tag <= pref_tag; m_pref <= 1'b1; m_merged <= 1'b0;
        end
      end else begin
        if (!m_sent && mem_ready) m_sent <= 1'b1;
        if (m_merge_ok) m_merged <= 1'b1;
      end
    end
  end

  logic [1:0]    e_state;
  logic          e_mem_valid, e_dmd_ready, e_pref_ready;
  logic [TW-1:0] e_mem_tag;
  assign e_state      = !m_busy ? 2'd0 : (!m_sent ? 2'd1 : 2'd2);
  assign e_mem_valid  = m_busy && !m_sent;
  assign e_mem_tag    = e_mem_valid ? m_tag : '0;
  assign e_dmd_ready  = Rst && (!m_busy || m_merge_ok);
  assign e_pref_ready = Rst && !m_busy && !dmd_valid;

  always @(negedge Clock) begin
    if (model_ok) begin
      chk("state",      {30'd0, current_stateOut}, {30'd0, e_state});
      chk("dmd_ready",  {31'd0, dmd_reqReadyOut},  {31'd0, e_dmd_ready});
      chk("pref_ready", {31'd0, pref_reqReadyOut}, {31'd0, e_pref_ready});
      chk("mem_valid",  {31'd0, mem_reqValidOut},  {31'd0, e_mem_valid});
      chk("mem_tag",    {4'd0, mem_reqTagOut},     {4'd0, e_mem_tag});
      chk("dmd_rsp",    {31'd0, dmd_rspValidOut},  {31'd0, m_dmd_pulse});
      chk("pref_rsp",   {31'd0, pref_rspValidOut}, {31'd0, m_pref_pulse});
      chk("rsp_tag",    {4'd0, rspTagOut},         {4'd0, m_rsp_tag});
      chk("err_stray",  {31'd0, errStrayOut},      {31'd0, m_err});
      if (mem_reqValidOut && mem_ready && Rst) hs_cnt <= hs_cnt + 1;
      if (dmd_rspValidOut) dp_cnt <= dp_cnt + 1;
      if (pref_rspValidOut) pp_cnt <= pp_cnt + 1;
      if (dmd_rspValidOut && pref_rspValidOut) both_cnt <= both_cnt + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int hs0, dp0, pp0, both0;
  logic acc;

  initial begin
    Rst = 1'b0; dmd_valid = 1'b1; dmd_tag = 28'h55; pref_valid = 1'b0; pref_tag = '0;
    mem_ready = 1'b0; rsp_valid = 1'b0; rsp_tag_in = '0;

    // reset: readies held low even with valids asserted
    cyc(1);
    chk("rst_state", {30'd0, current_stateOut}, 32'd0);
    chk("rst_dmd_ready", {31'd0, dmd_reqReadyOut}, 32'd0);
    dmd_valid = 1'b0; pref_valid = 1'b1;
    #1;
    chk("rst_pref_ready", {31'd0, pref_reqReadyOut}, 32'd0);
    cyc(1);
    chk("rst_mem_valid", {31'd0, mem_reqValidOut}, 32'd0);
    chk("rst_err", {31'd0, errStrayOut}, 32'd0);
    pref_valid = 1'b0; Rst = 1'b1; mem_ready = 1'b1;
    cyc(1);
    $display("[tb] reset checked");

    // demand only, tag 0x100
    dmd_valid = 1'b1; dmd_tag = 28'h100;
    cyc(1); dmd_valid = 1'b0;
    chk("d_state_req", {30'd0, current_stateOut}, 32'd1);
    chk("d_mem_valid", {31'd0, mem_reqValidOut}, 32'd1);
    chk("d_mem_tag", {4'd0, mem_reqTagOut}, 32'h100);
    cyc(1);
    chk("d_state_wait", {30'd0, current_stateOut}, 32'd2);
    rsp_valid = 1'b1; rsp_tag_in = 28'h100;
    cyc(1); rsp_valid = 1'b0;
    chk("d_pulse", {31'd0, dmd_rspValidOut}, 32'd1);
    chk("d_rsp_tag", {4'd0, rspTagOut}, 32'h100);
    chk("d_state_idle", {30'd0, current_stateOut}, 32'd0);
    cyc(1);
    chk("d_pulse_end", {31'd0, dmd_rspValidOut}, 32'd0);
    chk("d_rsp_tag_zero", {4'd0, rspTagOut}, 32'd0);
    $display("[tb] demand-only 0x100 done");

    // simultaneous demand 0x200 / prefetch 0x201
    dmd_valid = 1'b1; dmd_tag = 28'h200; pref_valid = 1'b1; pref_tag = 28'h201;
    #1;
    chk("p_pref_blocked", {31'd0, pref_reqReadyOut}, 32'd0);
    cyc(1); dmd_valid = 1'b0;
    chk("p_mem_tag_dmd", {4'd0, mem_reqTagOut}, 32'h200);
    cyc(1);
    rsp_valid = 1'b1; rsp_tag_in = 28'h200;
    cyc(1); rsp_valid = 1'b0;
    chk("p_dmd_pulse", {31'd0, dmd_rspValidOut}, 32'd1);
    chk("p_pref_ready_on_pulse", {31'd0, pref_reqReadyOut}, 32'd1);
    cyc(1); pref_valid = 1'b0;
    chk("p_mem_tag_pref", {4'd0, mem_reqTagOut}, 32'h201);
    cyc(1);
    rsp_valid = 1'b1; rsp_tag_in = 28'h201;
    cyc(1); rsp_valid = 1'b0;
    chk("p_pref_pulse", {31'd0, pref_rspValidOut}, 32'd1);
    chk("p_rsp_tag", {4'd0, rspTagOut}, 32'h201);
    cyc(1);
    $display("[tb] priority 0x200/0x201 done");

    // backpressure for three cycles
    mem_ready = 1'b0; dmd_valid = 1'b1; dmd_tag = 28'h3A5;
    cyc(1); dmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_state", {30'd0, current_stateOut}, 32'd1);
      chk("b_mem_tag", {4'd0, mem_reqTagOut}, 32'h3A5);
      cyc(1);
    end
    mem_ready = 1'b1;
    cyc(1);
    chk("b_state_wait", {30'd0, current_stateOut}, 32'd2);
    rsp_valid = 1'b1; rsp_tag_in = 28'h3A5;
    cyc(1); rsp_valid = 1'b0;
    cyc(1);
    $display("[tb] backpressure 0x3A5 done");

    // stray tag in WAIT
    pref_valid = 1'b1; pref_tag = 28'h301;
    cyc(1); pref_valid = 1'b0;
    cyc(1);
    rsp_valid = 1'b1; rsp_tag_in = 28'h300;
    cyc(1); rsp_valid = 1'b0;
    chk("s_err", {31'd0, errStrayOut}, 32'd1);
    chk("s_state_wait", {30'd0, current_stateOut}, 32'd2);
    chk("s_no_pulse", {31'd0, pref_rspValidOut}, 32'd0);
    rsp_valid = 1'b1; rsp_tag_in = 28'h301;
    cyc(1); rsp_valid = 1'b0;
    chk("s_pulse", {31'd0, pref_rspValidOut}, 32'd1);
    chk("s_rsp_tag", {4'd0, rspTagOut}, 32'h301);
    cyc(1);
    $display("[tb] stray 0x300 vs 0x301 done");

    // demand for a line the prefetcher already has in flight
    hs0 = hs_cnt; dp0 = dp_cnt; pp0 = pp_cnt; both0 = both_cnt;
    pref_valid = 1'b1; pref_tag = 28'h101;
    cyc(1); pref_valid = 1'b0;
    cyc(1);
    dmd_valid = 1'b1; dmd_tag = 28'h101;
    #1;
    chk("m_dmd_ready_wait", {31'd0, dmd_reqReadyOut}, {31'd0, MERGE});
    for (int i = 0; i < 12; i++) begin
      acc = dmd_valid && dmd_reqReadyOut;
      rsp_valid = (current_stateOut == 2'd2);
      rsp_tag_in = 28'h101;
      cyc(1);
      rsp_valid = 1'b0;
      if (acc) dmd_valid = 1'b0;
    end
    chk("m_dmd_served", {31'd0, dmd_valid}, 32'd0);
    chk("m_mem_requests", hs_cnt - hs0, MERGE ? 32'd1 : 32'd2);
    chk("m_dmd_pulses", dp_cnt - dp0, 32'd1);
    chk("m_pref_pulses", pp_cnt - pp0, 32'd1);
    chk("m_joint_pulses", both_cnt - both0, {31'd0, MERGE});
    $display("[tb] shared line 0x101 done");

    // reset while waiting, then a late response is stray
    dmd_valid = 1'b1; dmd_tag = 28'h0AB;
    cyc(1); dmd_valid = 1'b0;
    cyc(1);
    Rst = 1'b0;
    cyc(1);
    chk("r_state", {30'd0, current_stateOut}, 32'd0);
    chk("r_mem_valid", {31'd0, mem_reqValidOut}, 32'd0);
    chk("r_err_clear", {31'd0, errStrayOut}, 32'd0);
    chk("r_dmd_ready", {31'd0, dmd_reqReadyOut}, 32'd0);
    Rst = 1'b1;
    rsp_valid = 1'b1; rsp_tag_in = 28'h0AB;
    cyc(1); rsp_valid = 1'b0;
    chk("r_err_late", {31'd0, errStrayOut}, 32'd1);
    chk("r_no_pulse", {31'd0, dmd_rspValidOut}, 32'd0);
    cyc(2);
    $display("[tb] reset in WAIT done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_mem_arb.md
IFU_MEM_ARB -- requirements
Module: ifu_mem_arb

Interface
REQ-001 SHALL have parameter: TAG_WIDTH, 28, line-tag width (ADDR_WIDTH 32 minus OFFSET_WIDTH 4).
REQ-002 SHALL have port: Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: Rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: dmd_reqValidIn in 1, dmd_reqTagIn in TAG_WIDTH, dmd_reqReadyOut out 1; demand (CPU-miss) request channel.
REQ-005 SHALL have ports: pref_reqValidIn in 1, pref_reqTagIn in TAG_WIDTH, pref_reqReadyOut out 1; prefetcher request channel.
REQ-006 SHALL have ports: mem_reqValidOut out 1, mem_reqTagOut out TAG_WIDTH, mem_reqReadyIn in 1; shared memory request port.
REQ-007 SHALL have ports: mem_rspValidIn in 1, mem_rspTagIn in TAG_WIDTH; memory line-return indication.
REQ-008 SHALL have ports: dmd_rspValidOut out 1, pref_rspValidOut out 1, rspTagOut out TAG_WIDTH; routed response pulses and their tag.
REQ-009 SHALL have ports: current_stateOut out 2 (FSM encoding), errStrayOut out 1 (sticky stray-response flag).

Function
REQ-010 SHALL implement FSM IDLE=0, REQ=1, WAIT=2; encoding 3 unreachable and SHALL go to IDLE.
REQ-011 SHALL allow exactly one outstanding memory request.
REQ-012 IDLE: dmd_reqReadyOut=1; pref_reqReadyOut=1 only when dmd_reqValidIn=0 (demand has fixed priority).
REQ-013 A channel is accepted when valid and ready are both 1; SHALL capture tag and owner (DMD/PREF), go to REQ next cycle.
REQ-014 REQ: mem_reqValidOut=1, mem_reqTagOut=captured tag, held stable until mem_reqReadyIn=1; on that cycle go to WAIT.
REQ-015 WAIT: mem_rspValidIn=1 with mem_rspTagIn==captured tag SHALL, next cycle, pulse owner's rsp valid for exactly 1 cycle with rspTagOut=captured tag, and state returns to IDLE.
REQ-016 Minimum latency: accept cycle N, mem_reqValidOut at N+1, response pulse one cycle after matching mem_rspValidIn.
REQ-017 New request SHALL be acceptable in the same cycle as the response pulse (state IDLE).
REQ-018 mem_rspValidIn in IDLE or REQ, or in WAIT with mismatched tag, SHALL be ignored for routing and set errStrayOut=1 (sticky until reset).
REQ-019 Outside IDLE both readies SHALL be 0, except per REQ-024.
REQ-020 mem_reqTagOut SHALL be 0 whenever mem_reqValidOut=0; rspTagOut 0 when no pulse.

Reset
REQ-021 Rst=0 at a rising edge SHALL force: state IDLE, owner/tag/merge cleared, all outputs 0, errStrayOut 0.
REQ-022 Reset mid-operation (REQ or WAIT) SHALL drop the outstanding request with no response pulse; a later returning response is stray (REQ-018).
REQ-023 While Rst=0 both readies SHALL be 0.

Configuration
REQ-024 Macro IFU_ARB_MERGE_EN: when defined, in REQ or WAIT with owner PREF, dmd_reqValidIn=1 and dmd_reqTagIn==captured tag SHALL give dmd_reqReadyOut=1, set merge flag, issue no new memory request; on the matching response both dmd_rspValidOut and pref_rspValidOut pulse in the same cycle. Merge in the same cycle as the matching response SHALL be honoured.
REQ-025 Without IFU_ARB_MERGE_EN: demand stalls (ready 0) until IDLE, then issues its own memory request.

Verification
REQ-026 Demand only: dmd tag 0x100, mem_reqReadyIn=1 -> mem_reqTagOut=0x100 next cycle; rsp 0x100 -> dmd_rspValidOut 1 cycle, rspTagOut=0x100.
REQ-027 Simultaneous dmd 0x200 and pref 0x201 in IDLE -> demand granted, pref_reqReadyOut=0; pref 0x201 issued after 0x200 response.
REQ-028 Backpressure: mem_reqReadyIn=0 for 3 cycles -> mem_reqValidOut held 1, tag stable, state REQ; then WAIT.
REQ-029 Stray: rsp tag 0x300 in WAIT for 0x301 -> no pulse, errStrayOut=1, still WAIT; rsp 0x301 then completes.
REQ-030 Merge (macro on): pref 0x101 in WAIT, dmd 0x101 -> dmd accepted, one memory request; both pulses. Macro off -> dmd_reqReadyOut=0 until IDLE, second request for 0x101.
REQ-031 Reset in WAIT -> state 0, outputs 0; subsequent rsp -> errStrayOut=1, no pulse.
